// File: rtl/xy2_100_tx_if.sv
// Word handshake and XY2-100 line signals of the xy2_100_tx transmitter.
interface xy2_100_tx_if;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        in_valid;
  logic        in_ready;
  logic        xy_clk;
  logic        xy_sync;
  logic        xy_x;
  logic        xy_y;
  logic        frame_start;
  logic        frame_done;

  modport master (
    output in_x, in_y, in_valid,
    input  in_ready, xy_clk, xy_sync, xy_x, xy_y, frame_start, frame_done
  );

  modport slave (
    input  in_x, in_y, in_valid,
    output in_ready, xy_clk, xy_sync, xy_x, xy_y, frame_start, frame_done
  );
endinterface

// File: rtl/xy2_100_tx.sv
// XY2-100 transmitter: sends X/Y position words as continuous back-to-back
// 20-bit frames, with a one-entry buffer between the host and the frame loader.
module xy2_100_tx #(
  parameter int unsigned HALF_DIV = 5,
  parameter logic [15:0] IDLE_POS = 16'h8000
) (
  input  logic        clk_ref,
  input  logic        sys_rstn,
  xy2_100_tx_if.slave bus
);
  localparam int unsigned PERIOD  = 2 * HALF_DIV;
  localparam int unsigned PHASE_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned WORD_W  = 16;
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(19);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PERIOD - 1);
  localparam logic [PHASE_W-1:0] FALL_PHASE = PHASE_W'(HALF_DIV);

  typedef enum logic {ST_START, ST_RUN} state_e;

  state_e              state_q,       state_d;
  logic [PHASE_W-1:0]  phase_q,       phase_d;
  logic [BIT_W-1:0]    bit_q,         bit_d;
  logic [WORD_W-1:0]   x_hold_q,      x_hold_d;
  logic [WORD_W-1:0]   y_hold_q,      y_hold_d;
  logic [WORD_W-1:0]   x_pend_q,      x_pend_d;
  logic [WORD_W-1:0]   y_pend_q,      y_pend_d;
  logic                in_ready_q,    in_ready_d;
  logic                xy_clk_q,      xy_clk_d;
  logic                xy_sync_q,     xy_sync_d;
  logic                xy_x_q,        xy_x_d;
  logic                xy_y_q,        xy_y_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q,  frame_done_d;
  logic                load;
  logic                accept;

  // Line value of frame bit idx: control 0,0,1, data MSB first, then even parity.
  function automatic logic bit_value(input logic [WORD_W-1:0] word,
                                     input logic [BIT_W-1:0]  idx);
    logic v;
    v = 1'b0;
    if (idx == BIT_W'(2)) begin
      v = 1'b1;
    end else if ((idx >= BIT_W'(3)) && (idx < LAST_BIT)) begin
      v = word[4'(BIT_W'(18) - idx)];
    end else if (idx == LAST_BIT) begin
      v = ~(^word);
    end
    return v;
  endfunction

  always_ff @(posedge clk_ref) begin
    if (!sys_rstn) begin
      state_q       <= ST_START;
      phase_q       <= '0;
      bit_q         <= '0;
      x_hold_q      <= IDLE_POS;
      y_hold_q      <= IDLE_POS;
      x_pend_q      <= IDLE_POS;
      y_pend_q      <= IDLE_POS;
      in_ready_q    <= 1'b1;
      xy_clk_q      <= 1'b0;
      xy_sync_q     <= 1'b0;
      xy_x_q        <= 1'b0;
      xy_y_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_q         <= bit_d;
      x_hold_q      <= x_hold_d;
      y_hold_q      <= y_hold_d;
      x_pend_q      <= x_pend_d;
      y_pend_q      <= y_pend_d;
      in_ready_q    <= in_ready_d;
      xy_clk_q      <= xy_clk_d;
      xy_sync_q     <= xy_sync_d;
      xy_x_q        <= xy_x_d;
      xy_y_q        <= xy_y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    bit_d         = bit_q;
    x_hold_d      = x_hold_q;
    y_hold_d      = y_hold_q;
    x_pend_d      = x_pend_q;
    y_pend_d      = y_pend_q;
    in_ready_d    = in_ready_q;
    xy_clk_d      = xy_clk_q;
    xy_sync_d     = xy_sync_q;
    xy_x_d        = xy_x_q;
    xy_y_d        = xy_y_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;

    // First edge after reset enters bit 0 phase 0 without advancing the counters.
    case (state_q)
      ST_START: begin
        state_d = ST_RUN;
        phase_d = '0;
        bit_d   = '0;
      end
      ST_RUN: begin
        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          bit_d   = (bit_q == LAST_BIT) ? '0 : bit_q + BIT_W'(1);
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      default: state_d = ST_START;
    endcase

    load   = (phase_d == '0) && (bit_d == '0);
    accept = bus.in_valid && in_ready_q;

    // Buffer full blocks acceptance, so load and accept never both touch pending.
    if (load && !in_ready_q) begin
      x_hold_d   = x_pend_q;
      y_hold_d   = y_pend_q;
      in_ready_d = 1'b1;
    end
    if (accept) begin
      x_pend_d   = bus.in_x;
      y_pend_d   = bus.in_y;
      in_ready_d = 1'b0;
    end

    if (phase_d == '0) begin
      xy_clk_d  = 1'b1;
      xy_sync_d = (bit_d != LAST_BIT);
      xy_x_d    = bit_value(x_hold_q, bit_d);
      xy_y_d    = bit_value(y_hold_q, bit_d);
    end
    if (phase_d == FALL_PHASE) begin
      xy_clk_d = 1'b0;
    end

    frame_start_d = load;
    frame_done_d  = (bit_d == LAST_BIT) && (phase_d == LAST_PHASE);
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.xy_clk      = xy_clk_q;
  assign bus.xy_sync     = xy_sync_q;
  assign bus.xy_x        = xy_x_q;
  assign bus.xy_y        = xy_y_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_xy2_100_tx.sv
// Bench for xy2_100_tx: cycle model of the line timing, frame decoder on the
// falling xy_clk edge, vector table, corner sequences and a HALF_DIV=1 stream.
module tb_xy2_100_tx;
  localparam int H      = 5;
  localparam int PER    = 2 * H;
  localparam int FRAME  = 20 * PER;
  localparam int FRAME2 = 40;
  localparam logic [15:0] IDLE = 16'h8000;

  logic clk_ref = 1'b0;
  logic rstn;
  logic rstn2;
  always #5 clk_ref = ~clk_ref;

  xy2_100_tx_if bus ();
  xy2_100_tx_if bus2 ();

  xy2_100_tx #(.HALF_DIV(H), .IDLE_POS(IDLE)) dut (
    .clk_ref(clk_ref), .sys_rstn(rstn), .bus(bus));
  xy2_100_tx #(.HALF_DIV(1), .IDLE_POS(IDLE)) dut2 (
    .clk_ref(clk_ref), .sys_rstn(rstn2), .bus(bus2));

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [19:0] fx;
    logic [19:0] fy;
  } vec_t;
  vec_t vecs [4];

  int n_checks = 0;
  int n_errors = 0;
  // Reference model state: cycle index since release, pending buffer, hold words.
  int          m_t = -1;
  logic        m_full = 1'b0;
  logic        m_acc = 1'b0;
  logic [15:0] m_hx = IDLE, m_hy = IDLE, m_px = '0, m_py = '0;
  int          cyc = 0;
  int          fs_last = -1;
  int          fs_period = 0;
  logic        dclk_prev = 1'b0;
  logic [19:0] sx = '0, sy = '0, last_fx = '0, last_fy = '0;
  int          last_idx = -1;
  logic        dec_flag = 1'b0;
  logic [6:0]  last_got = '0;
  logic [39:0] dec_by_idx [int];

  function automatic logic [19:0] build_frame(input logic [15:0] w);
    return {3'b001, w, ~(^w)};
  endfunction

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
  endtask

  // One clk_ref cycle: advance the model at the edge, compare on the falling edge.
  task automatic step();
    int pos, b, ph;
    logic [19:0] fx, fy;
    logic [6:0] exp_v;
    @(posedge clk_ref);
    if (!rstn) begin
      m_t = -1; m_full = 1'b0; m_acc = 1'b0; m_hx = IDLE; m_hy = IDLE;
    end else begin
      m_acc = bus.in_valid && !m_full;
      m_t++;
      pos = m_t % FRAME;
      if (pos == 0 && m_full) begin
        m_hx = m_px; m_hy = m_py; m_full = 1'b0;
      end
      if (m_acc) begin
        m_px = bus.in_x; m_py = bus.in_y; m_full = 1'b1;
      end
    end
    if (m_t < 0) begin
      exp_v = 7'b0000001;
    end else begin
      pos = m_t % FRAME;
      b   = pos / PER;
      ph  = pos % PER;
      fx  = build_frame(m_hx);
      fy  = build_frame(m_hy);
      exp_v = {(ph < H), (b != 19), fx[19-b], fy[19-b], (pos == 0), (pos == FRAME-1), !m_full};
    end
    @(negedge clk_ref);
    cyc++;
    last_got = {bus.xy_clk, bus.xy_sync, bus.xy_x, bus.xy_y,
                bus.frame_start, bus.frame_done, bus.in_ready};
    check($sformatf("cycle%0d clk/sync/x/y/fs/fd/rdy", cyc), 40'(last_got), 40'(exp_v));
    dec_flag = 1'b0;
    if (m_t >= 0) begin
      if (bus.frame_start) begin
        if (fs_last >= 0) fs_period = cyc - fs_last;
        fs_last = cyc;
      end
      if (dclk_prev && !bus.xy_clk) begin
        sx = {sx[18:0], bus.xy_x};
        sy = {sy[18:0], bus.xy_y};
        if (!bus.xy_sync) begin
          last_fx = sx; last_fy = sy; last_idx = m_t / FRAME;
          dec_by_idx[last_idx] = {sx, sy};
          dec_flag = 1'b1;
        end
      end
      dclk_prev = bus.xy_clk;
    end else begin
      dclk_prev = 1'b0;
      fs_last = -1;
      dec_by_idx.delete();
    end
  endtask

  task automatic wait_frame(input int idx, input string name, input logic [39:0] exp);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(dec_flag && last_idx == idx) && n < 3 * FRAME);
    if (dec_flag && last_idx == idx) check(name, {last_fx, last_fy}, exp);
    else fail_timeout(name);
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, output int acc_idx);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_x = x; bus.in_y = y;
    do begin
      step();
      n++;
    end while (!m_acc && n < 3 * FRAME);
    bus.in_valid = 1'b0;
    acc_idx = m_t / FRAME;
    if (!m_acc) fail_timeout("send");
  endtask

  task automatic step_until_pos(input int p, input logic need_empty);
    int n = 0;
    while (!((m_t % FRAME) == p && (!need_empty || !m_full)) && n < 3 * FRAME) begin
      step();
      n++;
    end
  endtask

  initial begin
    int acc_idx;
    int acc_idx_q[$];
    logic [15:0] acc_w_q[$];
    logic [15:0] w;
    logic [31:0] q2[$];
    logic [31:0] e2;
    logic rdy2, clk2_prev;
    logic [19:0] s2x, s2y;
    int frames2, n;

    vecs[0] = '{x: 16'h0000, y: 16'hFFFF, fx: 20'h20001, fy: 20'h3FFFF};
    vecs[1] = '{x: 16'h1234, y: 16'hAAAA, fx: 20'h22468, fy: 20'h35555};
    vecs[2] = '{x: 16'h0001, y: 16'hFFFE, fx: 20'h20002, fy: 20'h3FFFC};
    vecs[3] = '{x: 16'h8000, y: 16'h7FFF, fx: 20'h30000, fy: 20'h2FFFE};

    rstn = 1'b0; rstn2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0;
    bus2.in_valid = 1'b0; bus2.in_x = '0; bus2.in_y = '0;

    // Reset state
    repeat (3) step();
    check("reset_state", 40'(last_got), 40'(7'b0000001));

    // Idle frames of mid-scale and frame_start spacing
    rstn = 1'b1;
    wait_frame(0, "idle_frame0", {20'h30000, 20'h30000});
    wait_frame(1, "idle_frame1", {20'h30000, 20'h30000});
    check("frame_start_period", 40'(fs_period), 40'(FRAME));

    // Mid-frame acceptance: current frame keeps the old word
    repeat (50) step();
    send(16'h0000, 16'hFFFF, acc_idx);
    wait_frame(acc_idx, "midframe_current", {20'h30000, 20'h30000});
    wait_frame(acc_idx + 1, "midframe_next", {20'h20001, 20'h3FFFF});

    // Vector table at varied frame positions
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 150)) step();
      send(vecs[i].x, vecs[i].y, acc_idx);
      wait_frame(acc_idx + 1, $sformatf("vec%0d", i), {vecs[i].fx, vecs[i].fy});
    end

    // Acceptance on the load edge with an empty buffer
    step_until_pos(FRAME - 1, 1'b1);
    bus.in_valid = 1'b1; bus.in_x = 16'h1234; bus.in_y = 16'h00FF;
    step();
    bus.in_valid = 1'b0;
    acc_idx = m_t / FRAME;
    wait_frame(acc_idx, "collision_current", {vecs[3].fx, vecs[3].fy});
    wait_frame(acc_idx + 1, "collision_next", {20'h22468, 20'h201FF});

    // Continuous in_valid with incrementing words: one per frame, none lost
    w = 16'h0100;
    bus.in_valid = 1'b1; bus.in_x = w; bus.in_y = ~w;
    n = 0;
    while (acc_w_q.size() < 5 && n < 10 * FRAME) begin
      step();
      n++;
      if (m_acc) begin
        acc_w_q.push_back(w);
        acc_idx_q.push_back(m_t / FRAME);
        w++;
        bus.in_x = w; bus.in_y = ~w;
      end
    end
    bus.in_valid = 1'b0;
    if (acc_w_q.size() < 5) begin
      fail_timeout("stream_accept");
    end else begin
      wait_frame(acc_idx_q[4] + 1, "stream_last",
                 {build_frame(acc_w_q[4]), build_frame(~acc_w_q[4])});
      for (int k = 0; k < 4; k++) begin
        if (dec_by_idx.exists(acc_idx_q[k] + 1))
          check($sformatf("stream%0d", k), dec_by_idx[acc_idx_q[k] + 1],
                {build_frame(acc_w_q[k]), build_frame(~acc_w_q[k])});
        else
          fail_timeout($sformatf("stream%0d", k));
      end
    end

    // Reset at bit 10 with a word pending: frame abandoned, restart at mid-scale
    step_until_pos(2 * PER, 1'b1);
    send(16'h5555, 16'h5555, acc_idx);
    step_until_pos(10 * PER + 2, 1'b0);
    rstn = 1'b0;
    step();
    check("abort_reset", 40'(last_got), 40'(7'b0000001));
    rstn = 1'b1;
    wait_frame(0, "post_reset0", {20'h30000, 20'h30000});
    wait_frame(1, "post_reset1", {20'h30000, 20'h30000});

    // Random valid/data against the cycle model
    for (int i = 0; i < 10 * FRAME; i++) begin
      bus.in_valid = ($urandom_range(0, 3) == 0);
      bus.in_x = 16'($urandom);
      bus.in_y = 16'($urandom);
      step();
    end
    bus.in_valid = 1'b0;

    // HALF_DIV=1 instance: 1000 random words decoded on the falling xy_clk edge
    @(negedge clk_ref);
    rstn2 = 1'b1;
    bus2.in_valid = 1'b1;
    bus2.in_x = 16'($urandom); bus2.in_y = 16'($urandom);
    rdy2 = bus2.in_ready;
    clk2_prev = 1'b0;
    s2x = '0; s2y = '0;
    frames2 = 0; n = 0;
    while (frames2 < 1001 && n < 1100 * FRAME2) begin
      @(negedge clk_ref);
      n++;
      if (rdy2) begin
        q2.push_back({bus2.in_x, bus2.in_y});
        bus2.in_x = 16'($urandom); bus2.in_y = 16'($urandom);
      end
      rdy2 = bus2.in_ready;
      if (clk2_prev && !bus2.xy_clk) begin
        s2x = {s2x[18:0], bus2.xy_x};
        s2y = {s2y[18:0], bus2.xy_y};
        if (!bus2.xy_sync) begin
          if (frames2 == 0) begin
            e2 = {IDLE, IDLE};
            check("h1_frame0", {s2x, s2y}, {build_frame(e2[31:16]), build_frame(e2[15:0])});
          end else if (q2.size() == 0) begin
            fail_timeout("h1_queue");
          end else begin
            e2 = q2.pop_front();
            check($sformatf("h1_frame%0d", frames2), {s2x, s2y},
                  {build_frame(e2[31:16]), build_frame(e2[15:0])});
          end
          frames2++;
        end
      end
      clk2_prev = bus2.xy_clk;
    end
    if (frames2 < 1001) fail_timeout("h1_frames");
    bus2.in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
